// File: rtl/instruction_fetch_unit_if.sv
// Instruction-side bundle: memory address/data, execute redirect and the decode handshake.
interface instruction_fetch_unit_if;
   logic [31:0] ins_addr;
   logic [31:0] instruction;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;
   logic        fetch_error;

   modport master (
      output ins_addr, if_valid, if_instruction, if_pc, fetch_error,
      input  instruction, redirect_valid, redirect_pc, if_ready
   );

   modport slave (
      input  ins_addr, if_valid, if_instruction, if_pc, fetch_error,
      output instruction, redirect_valid, redirect_pc, if_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and
// buffers {pc, instruction} pairs in a small circular queue for decode.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input logic                       clk,
   input logic                       rst,
   instruction_fetch_unit_if.master  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t [DEPTH-1:0] q;
   entry_t             head;
   entry_t             last;
   logic [PW-1:0]      rd_ptr, wr_ptr;
   logic [CW-1:0]      count;
   logic [31:0]        pc;
   logic               fetch_error;
   logic               pop, push;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign head = q[rd_ptr];
   assign pop  = (count != '0) & bus.if_ready;
   assign push = ~bus.redirect_valid & ((count < CW'(DEPTH)) | pop);

   assign bus.ins_addr       = {2'b00, pc[31:2]};
   assign bus.if_valid       = (count != '0);
   // With the queue empty the outputs keep showing the entry decode last took.
   assign bus.if_instruction = (count != '0) ? head.instr : last.instr;
   assign bus.if_pc          = (count != '0) ? head.pc    : last.pc;
   assign bus.fetch_error    = fetch_error;

   always_ff @(posedge clk) begin
      if (!rst && push)
         q[wr_ptr] <= '{pc: pc, instr: bus.instruction};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         last        <= '0;
         fetch_error <= 1'b0;
      end else begin
         if (pop)
            last <= head;
         if (bus.redirect_valid) begin
            // Flush wins over fetch; a same-cycle pop still retires the head.
            pc     <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (bus.redirect_pc[1:0] != 2'b00)
               fetch_error <= 1'b1;
         end else begin
            if (push) begin
               wr_ptr <= inc(wr_ptr);
               pc     <= pc + 32'd4;
            end
            if (pop)
               rd_ptr <= inc(rd_ptr);
            if (push && !pop)
               count <= count + CW'(1);
            else if (pop && !push)
               count <= count - CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed vector bench for instruction_fetch_unit (DEPTH=2, RESET_PC=0).
module tb_instruction_fetch_unit;
   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] M0 = 32'h0030_0293, M1 = 32'h0040_0313, M2 = 32'h0053_03B3,
                           M3 = 32'h4053_0433, M4 = 32'h00A0_0493, M5 = 32'h0082_A8A3,
                           M6 = 32'h0000_0013, M7 = 32'hFFF0_0513;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'd0: return M0;
         32'd1: return M1;
         32'd2: return M2;
         32'd3: return M3;
         32'd4: return M4;
         32'd5: return M5;
         32'd6: return M6;
         32'd7: return M7;
         default: return 32'hDEAD_0000 | {16'h0, a[15:0]};
      endcase
   endfunction

   always_comb bus.instruction = mem_word(bus.ins_addr);

   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        chk;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] eins;
      logic [31:0] eaddr;
      logic        eerr;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                      input logic chk, input logic ev, input logic [31:0] epc,
                      input logic [31:0] eins, input logic [31:0] eaddr, input logic eerr);
      vec_t v;
      v = '{rst: r, rv: rv, rpc: rpc, rdy: rdy, chk: chk, ev: ev,
            epc: epc, eins: eins, eaddr: eaddr, eerr: eerr};
      tbl.push_back(v);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs after the falling edge, check outputs before the rising edge.
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      rst                = v.rst;
      bus.redirect_valid = v.rv;
      bus.redirect_pc    = v.rpc;
      bus.if_ready       = v.rdy;
      #1;
      if (v.chk) begin
         cmp({tag, " if_valid"},       {31'h0, bus.if_valid},    {31'h0, v.ev});
         cmp({tag, " ins_addr"},       bus.ins_addr,             v.eaddr);
         cmp({tag, " fetch_error"},    {31'h0, bus.fetch_error}, {31'h0, v.eerr});
         cmp({tag, " if_pc"},          bus.if_pc,                v.epc);
         cmp({tag, " if_instruction"}, bus.if_instruction,       v.eins);
      end
   endtask

   initial begin
      vec_t h;
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.if_ready       = 1'b0;

      //    rst rv  rpc            rdy chk v  if_pc          if_instr      ins_addr       err
      add(1, 0, 32'h0,          0, 0, 0, 32'h0,          32'h0,        32'h0,         0); // 0
      add(1, 0, 32'h0,          0, 1, 0, 32'h0,          32'h0,        32'h0,         0); // 1 reset state
      add(0, 0, 32'h0,          1, 1, 0, 32'h0,          32'h0,        32'h0,         0); // 2 release
      add(0, 0, 32'h0,          1, 1, 1, 32'h0,          M0,           32'h1,         0); // 3
      add(0, 0, 32'h0,          0, 1, 1, 32'h4,          M1,           32'h2,         0); // 4 stall x5
      add(0, 0, 32'h0,          0, 1, 1, 32'h4,          M1,           32'h3,         0); // 5 full
      add(0, 0, 32'h0,          0, 1, 1, 32'h4,          M1,           32'h3,         0); // 6
      add(0, 0, 32'h0,          0, 1, 1, 32'h4,          M1,           32'h3,         0); // 7
      add(0, 0, 32'h0,          0, 1, 1, 32'h4,          M1,           32'h3,         0); // 8
      add(0, 0, 32'h0,          1, 1, 1, 32'h4,          M1,           32'h3,         0); // 9 release
      add(0, 1, 32'h14,         1, 1, 1, 32'h8,          M2,           32'h4,         0); // 10 redirect
      add(0, 0, 32'h0,          1, 1, 0, 32'h8,          M2,           32'h5,         0); // 11 bubble
      add(0, 1, 32'h16,         1, 1, 1, 32'h14,         M5,           32'h6,         0); // 12 misaligned
      add(0, 0, 32'h0,          1, 1, 0, 32'h14,         M5,           32'h5,         1); // 13
      add(0, 1, 32'hFFFF_FFFC,  1, 1, 1, 32'h14,         M5,           32'h6,         1); // 14
      add(0, 0, 32'h0,          1, 1, 0, 32'h14,         M5,           32'h3FFF_FFFF, 1); // 15
      add(0, 0, 32'h0,          1, 1, 1, 32'hFFFF_FFFC,  32'hDEAD_FFFF, 32'h0,        1); // 16 wrap
      add(0, 0, 32'h0,          0, 1, 1, 32'h0,          M0,           32'h1,         1); // 17
      add(0, 0, 32'h0,          0, 1, 1, 32'h0,          M0,           32'h2,         1); // 18 full
      add(1, 0, 32'h0,          0, 1, 1, 32'h0,          M0,           32'h2,         1); // 19 reset
      add(0, 0, 32'h0,          0, 1, 0, 32'h0,          32'h0,        32'h0,         0); // 20
      add(0, 0, 32'h0,          0, 1, 1, 32'h0,          M0,           32'h1,         0); // 21

      foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

      // Redirect together with a pop while two entries are queued: only the head retires.
      h = '{rst: 0, rv: 1, rpc: 32'h8, rdy: 1, chk: 1, ev: 1, epc: 32'h0, eins: M0, eaddr: 32'h2, eerr: 0};
      apply(h, "rdpop0");
      h = '{rst: 0, rv: 0, rpc: 32'h0, rdy: 1, chk: 1, ev: 0, epc: 32'h0, eins: M0, eaddr: 32'h2, eerr: 0};
      apply(h, "rdpop1");
      h = '{rst: 0, rv: 0, rpc: 32'h0, rdy: 1, chk: 1, ev: 1, epc: 32'h8, eins: M2, eaddr: 32'h3, eerr: 0};
      apply(h, "rdpop2");

      // Back-to-back redirects: the second target is the one fetched.
      h = '{rst: 0, rv: 1, rpc: 32'h10, rdy: 1, chk: 1, ev: 1, epc: 32'hC, eins: M3, eaddr: 32'h4, eerr: 0};
      apply(h, "b2b0");
      h = '{rst: 0, rv: 1, rpc: 32'h1C, rdy: 1, chk: 1, ev: 0, epc: 32'hC, eins: M3, eaddr: 32'h4, eerr: 0};
      apply(h, "b2b1");
      h = '{rst: 0, rv: 0, rpc: 32'h0, rdy: 1, chk: 1, ev: 0, epc: 32'hC, eins: M3, eaddr: 32'h7, eerr: 0};
      apply(h, "b2b2");
      h = '{rst: 0, rv: 0, rpc: 32'h0, rdy: 1, chk: 1, ev: 1, epc: 32'h1C, eins: M7, eaddr: 32'h8, eerr: 0};
      apply(h, "b2b3");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Initiator side of the instruction memory interface: owns the program counter, drives the word address to the instruction memory, captures the returned instruction word and buffers it in a small queue for decode. The memory returns `instruction` combinationally for the `ins_addr` presented in the same cycle. Sits between the instruction memory and the decode stage. Accepts branch/jump redirects from execute.

## Interface
- `RESET_PC`, 32'h0000_0000: byte PC loaded on reset.
- `DEPTH`, 2: fetch queue entries; legal range 1–4.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ins_addr` output 32: word address to instruction memory = `{2'b00, pc[31:2]}`; combinational from `pc`.
- `instruction` input 32: instruction word for the current `ins_addr`, valid in the same cycle.
- `redirect_valid` input 1: load a new PC this cycle.
- `redirect_pc` input 32: byte target PC.
- `if_valid` output 1: queue head holds a valid instruction.
- `if_ready` input 1: decode accepts the head this cycle.
- `if_instruction` output 32: instruction at queue head.
- `if_pc` output 32: byte PC of that instruction.
- `fetch_error` output 1: sticky flag, set by a misaligned redirect.

## Operation
- State: `pc` (32 b), circular queue of `DEPTH` {pc, instruction} entries, read/write pointers, occupancy `count` (0..DEPTH), `fetch_error`.
- pop = `if_valid & if_ready`.
- push (no redirect) = `count < DEPTH` or pop. On push: write {`pc`, `instruction`} at the write pointer, then `pc <= pc + 4`.
- Full with no pop: no push; `pc` holds; `ins_addr` stable.
- Push and pop in the same cycle: `count` unchanged; both pointers advance.
- Pointers wrap modulo `DEPTH`. `pc` wraps 32'hFFFF_FFFC → 0. The upper bits of `ins_addr` are passed through untruncated.
- Redirect (`redirect_valid=1`) has priority over push:
  - Queue flushes: `count <= 0`, pointers reset.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - No push that cycle.
  - A pop in the same cycle is still a completed handshake. The popped entry is consumed, not replayed.
- Misaligned redirect (`redirect_pc[1:0] != 0`): `fetch_error <= 1`, which holds until `rst`. The aligned target is still loaded.
- `if_valid = (count != 0)`. `if_instruction`/`if_pc` come from the head entry. When `count == 0` they hold the last-popped entry's values. Decode must not sample them while `if_valid=0`.
- Reset mid-operation: the queue is discarded and all in-flight entries are lost. Fetch restarts from `RESET_PC` on the next edge.

## Timing
- Reset state (on the edge with `rst=1`):
  - `pc=RESET_PC`, so `ins_addr=RESET_PC>>2`.
  - `count=0`, `if_valid=0`.
  - `if_instruction=0`, `if_pc=0`, `fetch_error=0`.
- The first edge after reset deassertion pushes word `RESET_PC>>2`. `if_valid` rises on that edge, one cycle after reset release.
- Fetch-to-decode latency is 1 cycle. Sustained throughput is 1 instruction/cycle while `if_ready=1`.
- Redirect asserted in cycle t:
  - Cycle t+1: `if_valid=0`, `ins_addr=target>>2`.
  - Cycle t+2: `if_valid=1`, `if_pc=target`.
  - Redirect penalty: 1 bubble.
- `if_ready=0` with `if_valid=1`: head entry stable until popped. After `DEPTH` cycles of stall the queue is full and `ins_addr` freezes.
- Back-to-back redirects: the last one wins. Each flushes again.

## Test plan
- Reset then free-run, `if_ready=1`, memory words 0..3 = 0x00300293, 0x00400313, 0x005303B3, 0x40530433 → `ins_addr` 0,1,2,3,… per cycle. `if_valid` rises one cycle after reset release, then outputs (`if_pc`, `if_instruction`) = (0x0, 0x00300293), (0x4, 0x00400313), (0x8, 0x005303B3), (0xC, 0x40530433) on consecutive cycles.
- Backpressure: `if_ready=0` for 5 cycles starting at `if_pc=0x4` → `if_pc` stays 0x4, `count` reaches 2, `ins_addr` freezes at 3. On release, 0x4, 0x8, 0xC are delivered in order with no loss and no duplicates.
- Redirect to 0x14 while `if_pc=0x8` and `if_ready=1` → 0x8 is consumed. The next cycle has `if_valid=0`. The cycle after has `if_pc=0x14`, `if_instruction=mem[5]` (0x0082A8A3).
- Misaligned redirect to 0x16 → `fetch_error=1` and stays 1. Next delivered `if_pc=0x14`. Only `rst` clears `fetch_error`.
- Wrap and reset: redirect to 0xFFFF_FFFC → delivered PCs are 0xFFFF_FFFC then 0x0. `rst` asserted while the queue is full → next cycle `if_valid=0`, `ins_addr=RESET_PC>>2`. The queue contents are never delivered.
- Redirect and pop in the same cycle with `count=2` → exactly one entry is consumed (the head). The second entry is never presented.
